// File: rtl/rtc_cmd_sender_if.sv
// +--------------------------------------------------------------------+
// | rtc_cmd_sender_if : request handshake and RTC command bus           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface rtc_cmd_sender_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_reset_i;
  logic [4:0] req_hours_i;
  logic [5:0] req_minutes_i;
  logic [5:0] req_seconds_i;
  logic [9:0] req_milliseconds_i;
  logic       cmd_valid_o;
  logic [2:0] cmd_type_o;
  logic [9:0] cmd_data_o;
  logic       busy_o;
  logic       err_o;

  // Sender side: takes requests, drives the RTC command strobe.
  modport slave (
    input  req_valid_i, req_reset_i, req_hours_i, req_minutes_i,
           req_seconds_i, req_milliseconds_i,
    output req_ready_o, cmd_valid_o, cmd_type_o, cmd_data_o, busy_o, err_o
  );

  modport master (
    output req_valid_i, req_reset_i, req_hours_i, req_minutes_i,
           req_seconds_i, req_milliseconds_i,
    input  req_ready_o, cmd_valid_o, cmd_type_o, cmd_data_o, busy_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/rtc_cmd_sender.sv
// +--------------------------------------------------------------------+
// | rtc_cmd_sender : serialises a time / reset request into RTC cmds    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module rtc_cmd_sender #(
  parameter int CMD_GAP = 0
) (
  input  logic            clk_i,
  input  logic            srst_i,
  rtc_cmd_sender_if.slave bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SEND = 2'd1;
  localparam logic [1:0] c_GAP  = 2'd2;

  localparam logic [2:0] c_OP_HOURS   = 3'b111;
  localparam logic [2:0] c_OP_MINUTES = 3'b110;
  localparam logic [2:0] c_OP_SECONDS = 3'b101;
  localparam logic [2:0] c_OP_MS      = 3'b011;
  localparam logic [2:0] c_OP_RESET   = 3'b010;

  localparam logic [3:0] c_GAP_END = (CMD_GAP > 0) ? 4'(CMD_GAP - 1) : 4'd0;

  logic [1:0] r_state, w_state_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic [3:0] r_gap_cnt, w_gap_cnt_nxt;

  logic       r_is_reset;
  logic [4:0] r_hours;
  logic [5:0] r_minutes;
  logic [5:0] r_seconds;
  logic [9:0] r_ms;

  logic       r_cmd_valid, w_cmd_valid_d;
  logic [2:0] r_cmd_type, w_cmd_type_d;
  logic [9:0] r_cmd_data, w_cmd_data_d;
  logic       r_err, w_err_d;

  logic       w_ready, w_accept, w_legal, w_last;
  logic       w_src_reset;
  logic [4:0] w_src_hours;
  logic [5:0] w_src_minutes;
  logic [5:0] w_src_seconds;
  logic [9:0] w_src_ms;

  assign w_ready  = (r_state == c_IDLE) & ~srst_i;
  assign w_accept = bus.req_valid_i & w_ready;
  assign w_legal  = bus.req_reset_i |
                    ((bus.req_hours_i <= 5'd23) & (bus.req_minutes_i <= 6'd59) &
                     (bus.req_seconds_i <= 6'd59) & (bus.req_milliseconds_i <= 10'd999));
  assign w_last   = r_is_reset | (r_idx == 2'd3);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state     <= c_IDLE;
      r_idx       <= 2'd0;
      r_gap_cnt   <= 4'd0;
      r_is_reset  <= 1'b0;
      r_hours     <= 5'd0;
      r_minutes   <= 6'd0;
      r_seconds   <= 6'd0;
      r_ms        <= 10'd0;
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= 3'd0;
      r_cmd_data  <= 10'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_cmd_valid <= w_cmd_valid_d;
      r_cmd_type  <= w_cmd_type_d;
      r_cmd_data  <= w_cmd_data_d;
      r_err       <= w_err_d;
      if (w_accept) begin
        r_is_reset <= bus.req_reset_i;
        r_hours    <= bus.req_hours_i;
        r_minutes  <= bus.req_minutes_i;
        r_seconds  <= bus.req_seconds_i;
        r_ms       <= bus.req_milliseconds_i;
      end
    end
  end

  // r_idx advances when a command leaves SEND, so in GAP it already names the next one.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_gap_cnt_nxt = r_gap_cnt;
    case (r_state)
      c_IDLE: begin
        if (w_accept & w_legal) begin
          w_state_nxt = c_SEND;
          w_idx_nxt   = 2'd0;
        end
      end
      c_SEND: begin
        if (w_last) begin
          w_state_nxt = c_IDLE;
        end else begin
          w_idx_nxt     = r_idx + 2'd1;
          w_gap_cnt_nxt = 4'd0;
          w_state_nxt   = (CMD_GAP > 0) ? c_GAP : c_SEND;
        end
      end
      c_GAP: begin
        if (r_gap_cnt == c_GAP_END) w_state_nxt = c_SEND;
        else                        w_gap_cnt_nxt = r_gap_cnt + 4'd1;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so the registered strobe lines up with SEND.
  always_comb begin
    w_src_reset   = (r_state == c_IDLE) ? bus.req_reset_i        : r_is_reset;
    w_src_hours   = (r_state == c_IDLE) ? bus.req_hours_i        : r_hours;
    w_src_minutes = (r_state == c_IDLE) ? bus.req_minutes_i      : r_minutes;
    w_src_seconds = (r_state == c_IDLE) ? bus.req_seconds_i      : r_seconds;
    w_src_ms      = (r_state == c_IDLE) ? bus.req_milliseconds_i : r_ms;
    w_cmd_valid_d = (w_state_nxt == c_SEND);
    w_cmd_type_d  = 3'd0;
    w_cmd_data_d  = 10'd0;
    w_err_d       = w_accept & ~w_legal;
    if (w_cmd_valid_d) begin
      if (w_src_reset) begin
        w_cmd_type_d = c_OP_RESET;
      end else begin
        case (w_idx_nxt)
          2'd0: begin w_cmd_type_d = c_OP_HOURS;   w_cmd_data_d = {5'd0, w_src_hours};   end
          2'd1: begin w_cmd_type_d = c_OP_MINUTES; w_cmd_data_d = {4'd0, w_src_minutes}; end
          2'd2: begin w_cmd_type_d = c_OP_SECONDS; w_cmd_data_d = {4'd0, w_src_seconds}; end
          default: begin w_cmd_type_d = c_OP_MS;   w_cmd_data_d = w_src_ms;              end
        endcase
      end
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.busy_o      = (r_state != c_IDLE) & ~srst_i;
  assign bus.cmd_valid_o = r_cmd_valid;
  assign bus.cmd_type_o  = r_cmd_type;
  assign bus.cmd_data_o  = r_cmd_data;
  assign bus.err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rtc_cmd_sender.sv
// +--------------------------------------------------------------------+
// | tb_rtc_cmd_sender : directed vectors for rtc_cmd_sender (gap 0, 2)  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_rtc_cmd_sender;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  rtc_cmd_sender_if if0();
  rtc_cmd_sender_if if2();

  rtc_cmd_sender #(.CMD_GAP(0)) u_dut0 (.clk_i(clk), .srst_i(srst), .bus(if0));
  rtc_cmd_sender #(.CMD_GAP(2)) u_dut2 (.clk_i(clk), .srst_i(srst), .bus(if2));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic            rq;
    logic [4:0]      h;
    logic [5:0]      m;
    logic [5:0]      s;
    logic [9:0]      ms;
    logic            err;
    int              n;
    logic [3:0][2:0] typ;
    logic [3:0][9:0] dat;
  } vec_t;

  vec_t vecs[8];

  // Register-level RTC model fed by the gap-0 sender's command bus.
  logic [4:0] m_h;
  logic [5:0] m_m, m_s;
  logic [9:0] m_ms;
  always @(posedge clk) begin
    if (srst) begin
      m_h <= '1; m_m <= '1; m_s <= '1; m_ms <= '1;
    end else if (if0.cmd_valid_o) begin
      case (if0.cmd_type_o)
        3'b111: m_h  <= if0.cmd_data_o[4:0];
        3'b110: m_m  <= if0.cmd_data_o[5:0];
        3'b101: m_s  <= if0.cmd_data_o[5:0];
        3'b011: m_ms <= if0.cmd_data_o;
        3'b010: begin m_h <= '0; m_m <= '0; m_s <= '0; m_ms <= '0; end
        default: ;
      endcase
    end
  end

  function automatic vec_t mk(input logic rq, input int h, input int m, input int s,
                              input int ms, input logic err, input int n,
                              input int t0, input int d0, input int t1, input int d1,
                              input int t2, input int d2, input int t3, input int d3);
    vec_t v;
    v.rq = rq; v.h = 5'(h); v.m = 6'(m); v.s = 6'(s); v.ms = 10'(ms);
    v.err = err; v.n = n;
    v.typ[0] = 3'(t0); v.dat[0] = 10'(d0);
    v.typ[1] = 3'(t1); v.dat[1] = 10'(d1);
    v.typ[2] = 3'(t2); v.dat[2] = 10'(d2);
    v.typ[3] = 3'(t3); v.dat[3] = 10'(d3);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic rq, input int h, input int m,
                        input int s, input int ms);
    if0.req_valid_i        = v;
    if0.req_reset_i        = rq;
    if0.req_hours_i        = 5'(h);
    if0.req_minutes_i      = 6'(m);
    if0.req_seconds_i      = 6'(s);
    if0.req_milliseconds_i = 10'(ms);
  endtask

  // {valid, type, data, ready} of the gap-0 sender against an expected command.
  task automatic expect_cmd0(input string name, input int t, input int d);
    check(name, {if0.cmd_valid_o, if0.cmd_type_o, if0.cmd_data_o, if0.req_ready_o},
          {1'b1, 3'(t), 10'(d), 1'b0});
  endtask

  initial begin
    vecs[0] = mk(0, 12, 34, 56, 789, 0, 4, 7, 12, 6, 34, 5, 56, 3, 789);
    vecs[1] = mk(0, 23, 59, 59, 999, 0, 4, 7, 23, 6, 59, 5, 59, 3, 999);
    vecs[2] = mk(0, 24,  0,  0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk(0,  0,  0,  0, 1000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk(0,  0, 60,  0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5] = mk(0,  0,  0, 60,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6] = mk(1, 31, 63, 63, 1023, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    vecs[7] = mk(0,  0,  0,  0,   0, 0, 4, 7, 0, 6, 0, 5, 0, 3, 0);

    srst = 1'b1;
    drive0(0, 0, 0, 0, 0, 0);
    if2.req_valid_i = 1'b0; if2.req_reset_i = 1'b0; if2.req_hours_i = '0;
    if2.req_minutes_i = '0; if2.req_seconds_i = '0; if2.req_milliseconds_i = '0;

    // Reset state
    tick();
    tick();
    check("rst_ready0", {31'd0, if0.req_ready_o}, 32'd0);
    check("rst_outs0", {if0.cmd_valid_o, if0.cmd_type_o, if0.cmd_data_o, if0.err_o, if0.busy_o}, 32'd0);
    check("rst_outs2", {if2.cmd_valid_o, if2.cmd_type_o, if2.cmd_data_o, if2.err_o, if2.busy_o, if2.req_ready_o}, 32'd0);
    srst = 1'b0;
    #1;
    check("rst_release_ready", {if0.req_ready_o, if2.req_ready_o}, 32'd3);
    tick();

    // Table-driven requests on the gap-0 sender
    for (int i = 0; i < 8; i++) begin
      drive0(1, vecs[i].rq, vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].ms);
      #1;
      check($sformatf("v%0d_ready", i), {31'd0, if0.req_ready_o}, 32'd1);
      tick();
      drive0(0, 0, 31, 63, 63, 1023);
      if (vecs[i].err) begin
        check($sformatf("v%0d_err", i), {if0.err_o, if0.cmd_valid_o, if0.req_ready_o}, 32'b101);
        tick();
        check($sformatf("v%0d_err_clr", i), {if0.err_o, if0.cmd_valid_o, if0.req_ready_o}, 32'b001);
      end else begin
        for (int k = 0; k < vecs[i].n; k++) begin
          expect_cmd0($sformatf("v%0d_cmd%0d", i, k), vecs[i].typ[k], vecs[i].dat[k]);
          check($sformatf("v%0d_noerr%0d", i, k), {31'd0, if0.err_o}, 32'd0);
          tick();
        end
        check($sformatf("v%0d_done", i), {if0.cmd_valid_o, if0.req_ready_o, if0.busy_o}, 32'b010);
        if (vecs[i].rq)
          check($sformatf("v%0d_rtc", i), {m_h, m_m, m_s, m_ms}, 32'd0);
        else
          check($sformatf("v%0d_rtc", i), {m_h, m_m, m_s, m_ms},
                {vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].ms});
      end
    end

    // CMD_GAP=2: four commands two idle cycles apart, busy for 10 cycles
    if2.req_valid_i = 1'b1; if2.req_hours_i = 5'd23; if2.req_minutes_i = 6'd59;
    if2.req_seconds_i = 6'd59; if2.req_milliseconds_i = 10'd999;
    #1;
    check("gap_ready", {31'd0, if2.req_ready_o}, 32'd1);
    tick();
    if2.req_valid_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      logic [2:0] t;
      logic [9:0] d;
      t = 3'd0; d = 10'd0;
      if (c == 0) begin t = 3'b111; d = 10'd23;  end
      if (c == 3) begin t = 3'b110; d = 10'd59;  end
      if (c == 6) begin t = 3'b101; d = 10'd59;  end
      if (c == 9) begin t = 3'b011; d = 10'd999; end
      check($sformatf("gap_c%0d", c),
            {if2.busy_o, if2.req_ready_o, if2.cmd_valid_o, if2.cmd_type_o, if2.cmd_data_o},
            {1'b1, 1'b0, (c % 3 == 0), t, d});
      tick();
    end
    check("gap_done", {if2.busy_o, if2.req_ready_o, if2.cmd_valid_o}, 32'b010);

    // Error pulse followed by acceptance in the same cycle
    drive0(1, 0, 24, 0, 0, 0);
    tick();
    drive0(1, 0, 1, 1, 1, 1);
    #1;
    check("errb2b_err", {if0.err_o, if0.req_ready_o, if0.cmd_valid_o}, 32'b110);
    tick();
    drive0(0, 0, 0, 0, 0, 0);
    expect_cmd0("errb2b_cmd0", 7, 1);
    check("errb2b_errclr", {31'd0, if0.err_o}, 32'd0);
    tick(); tick(); tick(); tick();
    check("errb2b_idle", {if0.req_ready_o, if0.cmd_valid_o}, 32'b10);

    // Reset on the cycle after the second command aborts the sequence
    drive0(1, 0, 1, 2, 3, 4);
    tick();
    drive0(0, 0, 0, 0, 0, 0);
    expect_cmd0("abort_cmd0", 7, 1);
    tick();
    expect_cmd0("abort_cmd1", 6, 2);
    tick();
    srst = 1'b1;
    #1;
    check("abort_rst_rdy", {if0.req_ready_o, if0.busy_o}, 32'b00);
    tick();
    check("abort_outs", {if0.cmd_valid_o, if0.cmd_type_o, if0.cmd_data_o, if0.err_o, if0.busy_o}, 32'd0);
    srst = 1'b0;
    #1;
    check("abort_ready", {31'd0, if0.req_ready_o}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("abort_quiet%0d", c), {if0.cmd_valid_o, if0.busy_o}, 32'd0);
    end

    // Held req_valid with changing fields: only the captured request is sent
    drive0(1, 0, 1, 2, 3, 4);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive0(1, k[0], 10 + k, 20 + k, 30 + k, 900 + k);
      #1;
      case (k)
        0: expect_cmd0("hold_cmd0", 7, 1);
        1: expect_cmd0("hold_cmd1", 6, 2);
        2: expect_cmd0("hold_cmd2", 5, 3);
        default: expect_cmd0("hold_cmd3", 3, 4);
      endcase
      tick();
    end
    drive0(1, 0, 5, 6, 7, 8);
    #1;
    check("hold_ready", {if0.req_ready_o, if0.cmd_valid_o}, 32'b10);
    tick();
    drive0(0, 0, 0, 0, 0, 0);
    expect_cmd0("hold2_cmd0", 7, 5); tick();
    expect_cmd0("hold2_cmd1", 6, 6); tick();
    expect_cmd0("hold2_cmd2", 5, 7); tick();
    expect_cmd0("hold2_cmd3", 3, 8); tick();
    check("hold2_done", {if0.req_ready_o, if0.cmd_valid_o}, 32'b10);
    check("hold2_rtc", {m_h, m_m, m_s, m_ms}, {5'd5, 6'd6, 6'd7, 10'd8});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
